pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_incrementer.sv | 16 +
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch PC sequencer.
//   state_e        : sequencer states (BOOT, RUN, REDIRECT, HALT)
//   INSTR_BYTES    : size of one instruction, i.e. the sequential PC step
//   FLUSH_CNT_W    : width of the redirect flush counter (holds 1..7)
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_e;

    localparam int INSTR_BYTES = 4;
    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/pc_incrementer.sv
// Sequential next-fetch-address adder.
// Ports:
//   pc_i [63:0] : current fetch address
//   pc_o [63:0] : pc_i + INSTR_BYTES, wrapping modulo 2^64
module pc_incrementer
    import pc_seq_pkg::*;
(
    input  logic [63:0] pc_i,
    output logic [63:0] pc_o
);

    // The carry out of bit 63 is intentionally discarded: the address
    // space wraps silently and no flag is raised.
    assign pc_o = pc_i + 64'(INSTR_BYTES);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer with branch redirect, IF/ID flush
// generation, stall hold and a sticky misaligned-target fault.
// Parameters:
//   RESET_PC     : fetch address loaded on reset
//   FLUSH_CYCLES : cycles if_flush stays high after a redirect (1..7)
// Ports:
//   clk          : clock, all state changes on the rising edge
//   reset        : synchronous, active-high
//   stall        : hazard request to hold the fetch address
//   br_taken     : resolved branch is taken this cycle
//   br_target    : final branch target, meaningful when br_taken=1
//   pc           : registered fetch address
//   fetch_valid  : registered, pc holds a fetch to issue this cycle
//   if_flush     : registered, squash the instruction(s) in IF/ID
//   misalign     : registered sticky fault, taken target not word aligned
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter int          FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] pc,
    output logic        fetch_valid,
    output logic        if_flush,
    output logic        misalign
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

    state_e                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [63:0]            pc_q, pc_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic                   if_flush_q, if_flush_d;
    logic                   misalign_q, misalign_d;

    logic [63:0]            pc_inc;
    logic                   target_aligned;

    pc_incrementer u_pc_incrementer (
        .pc_i (pc_q),
        .pc_o (pc_inc)
    );

    assign target_aligned = (br_target[1:0] == 2'b00);

    // State register: reset overrides every concurrent input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BOOT;
            flush_cnt_q   <= '0;
            pc_q          <= RESET_PC;
            fetch_valid_q <= 1'b0;
            if_flush_q    <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            if_flush_q    <= if_flush_d;
            misalign_q    <= misalign_d;
        end
    end

    // Next-state and flush counter.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, REDIRECT: begin
                if (br_taken) begin
                    if (target_aligned) begin
                        // A redirect inside REDIRECT simply restarts the count.
                        state_d     = REDIRECT;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d     = HALT;
                        flush_cnt_d = '0;
                    end
                end else if (state_q == REDIRECT) begin
                    // Counts down on stalled cycles as well.
                    if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                        state_d     = RUN;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d     = BOOT;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        if_flush_d    = 1'b0;
        misalign_d    = misalign_q;
        case (state_q)
            BOOT: begin
                fetch_valid_d = 1'b1;
            end
            RUN, REDIRECT: begin
                if (br_taken) begin
                    // Branch wins over stall; a bad target freezes pc at
                    // its pre-branch value and still squashes IF/ID once.
                    if_flush_d = 1'b1;
                    if (target_aligned) begin
                        pc_d          = br_target;
                        fetch_valid_d = 1'b1;
                    end else begin
                        fetch_valid_d = 1'b0;
                        misalign_d    = 1'b1;
                    end
                end else begin
                    pc_d          = stall ? pc_q : pc_inc;
                    fetch_valid_d = 1'b1;
                    // Flush persists while more REDIRECT cycles remain.
                    if_flush_d    = (state_q == REDIRECT) &&
                                    (flush_cnt_q > FLUSH_CNT_W'(1));
                end
            end
            HALT: begin
                fetch_valid_d = 1'b0;
                misalign_d    = 1'b1;
            end
            default: begin
                pc_d          = RESET_PC;
                fetch_valid_d = 1'b0;
                misalign_d    = 1'b0;
            end
        endcase
    end

    assign pc          = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign if_flush    = if_flush_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic        fv;
        logic        fl;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: RESET_PC=0x1000, FLUSH_CYCLES=2
    logic        a_reset = 1'b1, a_stall = 1'b0, a_br = 1'b0;
    logic [63:0] a_tgt = '0;
    logic [63:0] a_pc;
    logic        a_fv, a_fl, a_mis;

    // DUT B: default RESET_PC (0), FLUSH_CYCLES=3
    logic        b_reset = 1'b1, b_stall = 1'b0, b_br = 1'b0;
    logic [63:0] b_tgt = '0;
    logic [63:0] b_pc;
    logic        b_fv, b_fl, b_mis;

    pc_sequencer #(.RESET_PC(64'h1000), .FLUSH_CYCLES(2)) u_dut_a (
        .clk         (clk),
        .reset       (a_reset),
        .stall       (a_stall),
        .br_taken    (a_br),
        .br_target   (a_tgt),
        .pc          (a_pc),
        .fetch_valid (a_fv),
        .if_flush    (a_fl),
        .misalign    (a_mis)
    );

    pc_sequencer #(.FLUSH_CYCLES(3)) u_dut_b (
        .clk         (clk),
        .reset       (b_reset),
        .stall       (b_stall),
        .br_taken    (b_br),
        .br_target   (b_tgt),
        .pc          (b_pc),
        .fetch_valid (b_fv),
        .if_flush    (b_fl),
        .misalign    (b_mis)
    );

    exp_t qa[$];
    exp_t qb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Drive one cycle of inputs to DUT A (sel=0) or B (sel=1) and queue the
    // outputs expected right after the next rising edge.
    task automatic cyc(input bit sel, input string nm,
                       input logic r, input logic s, input logic b,
                       input logic [63:0] t, input logic [63:0] epc,
                       input logic efv, input logic efl, input logic emis);
        exp_t e;
        e.name = nm;
        e.pc   = epc;
        e.fv   = efv;
        e.fl   = efl;
        e.mis  = emis;
        if (!sel) begin
            a_reset = r; a_stall = s; a_br = b; a_tgt = t;
            qa.push_back(e);
        end else begin
            b_reset = r; b_stall = s; b_br = b; b_tgt = t;
            qb.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string dut, input exp_t e, input logic [63:0] pc,
                         input logic fv, input logic fl, input logic mis);
        n_tests++;
        if (pc !== e.pc || fv !== e.fv || fl !== e.fl || mis !== e.mis) begin
            n_fail++;
            $display("FAIL %s.%s: got pc=%h fv=%b fl=%b mis=%b, want pc=%h fv=%b fl=%b mis=%b",
                     dut, e.name, pc, fv, fl, mis, e.pc, e.fv, e.fl, e.mis);
        end
    endtask

    // Monitor: one expectation per edge, compared 1 time unit after it.
    always @(posedge clk) begin
        exp_t ea;
        exp_t eb;
        #1;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            check("A", ea, a_pc, a_fv, a_fl, a_mis);
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            check("B", eb, b_pc, b_fv, b_fl, b_mis);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #2;
        //      sel name        r  s  b  target                  pc                      fv fl mis
        cyc(0, "rst0",      1, 0, 0, 64'h0,                64'h1000,               0, 0, 0);
        cyc(0, "rst_br",    1, 0, 1, 64'h40,               64'h1000,               0, 0, 0);
        cyc(0, "boot_run",  0, 0, 0, 64'h0,                64'h1000,               1, 0, 0);
        cyc(0, "run1004",   0, 0, 0, 64'h0,                64'h1004,               1, 0, 0);
        cyc(0, "run1008",   0, 0, 0, 64'h0,                64'h1008,               1, 0, 0);
        cyc(0, "br2000",    0, 0, 1, 64'h2000,             64'h2000,               1, 1, 0);
        cyc(0, "stl_rd1",   0, 1, 0, 64'h0,                64'h2000,               1, 1, 0);
        cyc(0, "stl_rd2",   0, 1, 0, 64'h0,                64'h2000,               1, 0, 0);
        cyc(0, "br3000",    0, 0, 1, 64'h3000,             64'h3000,               1, 1, 0);
        cyc(0, "rd3004",    0, 0, 0, 64'h0,                64'h3004,               1, 1, 0);
        cyc(0, "rd3008",    0, 0, 0, 64'h0,                64'h3008,               1, 0, 0);
        cyc(0, "stl_br40",  0, 1, 1, 64'h40,               64'h40,                 1, 1, 0);
        cyc(0, "rd44",      0, 0, 0, 64'h0,                64'h44,                 1, 1, 0);
        cyc(0, "stall44a",  0, 1, 0, 64'h0,                64'h44,                 1, 0, 0);
        cyc(0, "stall44b",  0, 1, 0, 64'h0,                64'h44,                 1, 0, 0);
        cyc(0, "stall44c",  0, 1, 0, 64'h0,                64'h44,                 1, 0, 0);
        cyc(0, "br100",     0, 0, 1, 64'h100,              64'h100,                1, 1, 0);
        cyc(0, "rebr200",   0, 0, 1, 64'h200,              64'h200,                1, 1, 0);
        cyc(0, "rd204",     0, 0, 0, 64'h0,                64'h204,                1, 1, 0);
        cyc(0, "rd208",     0, 0, 0, 64'h0,                64'h208,                1, 0, 0);
        cyc(0, "br_top",    0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 0);
        cyc(0, "wrap0",     0, 0, 0, 64'h0,                64'h0,                  1, 1, 0);
        cyc(0, "wrap4",     0, 0, 0, 64'h0,                64'h4,                  1, 0, 0);
        cyc(0, "br500",     0, 0, 1, 64'h500,              64'h500,                1, 1, 0);
        cyc(0, "stl500a",   0, 1, 0, 64'h0,                64'h500,                1, 1, 0);
        cyc(0, "stl500b",   0, 1, 0, 64'h0,                64'h500,                1, 0, 0);
        cyc(0, "br_mis",    0, 0, 1, 64'h1002,             64'h500,                0, 1, 1);
        cyc(0, "halt0",     0, 0, 0, 64'h0,                64'h500,                0, 0, 1);
        cyc(0, "halt_br",   0, 1, 1, 64'h800,              64'h500,                0, 0, 1);
        cyc(0, "halt_br2",  0, 0, 1, 64'h1001,             64'h500,                0, 0, 1);
        cyc(0, "rst_halt",  1, 1, 1, 64'h40,               64'h1000,               0, 0, 0);
        cyc(0, "boot2",     0, 0, 0, 64'h0,                64'h1000,               1, 0, 0);
        cyc(0, "run2",      0, 0, 0, 64'h0,                64'h1004,               1, 0, 0);

        cyc(1, "rst",       1, 0, 0, 64'h0,                64'h0,                  0, 0, 0);
        cyc(1, "boot_run",  0, 0, 0, 64'h0,                64'h0,                  1, 0, 0);
        cyc(1, "run4",      0, 0, 0, 64'h0,                64'h4,                  1, 0, 0);
        cyc(1, "br80",      0, 0, 1, 64'h80,               64'h80,                 1, 1, 0);
        cyc(1, "rd84",      0, 0, 0, 64'h0,                64'h84,                 1, 1, 0);
        cyc(1, "rst_mid",   1, 0, 0, 64'h0,                64'h0,                  0, 0, 0);
        cyc(1, "boot_run2", 0, 0, 0, 64'h0,                64'h0,                  1, 0, 0);
        cyc(1, "no_resid",  0, 0, 0, 64'h0,                64'h4,                  1, 0, 0);
        cyc(1, "br10",      0, 0, 1, 64'h10,               64'h10,                 1, 1, 0);
        cyc(1, "rd14",      0, 0, 0, 64'h0,                64'h14,                 1, 1, 0);
        cyc(1, "rd18",      0, 0, 0, 64'h0,                64'h18,                 1, 1, 0);
        cyc(1, "rd1c",      0, 0, 0, 64'h0,                64'h1C,                 1, 0, 0);
        cyc(1, "br_mis1",   0, 0, 1, 64'h21,               64'h1C,                 0, 1, 1);
        cyc(1, "halt",      0, 0, 0, 64'h0,                64'h1C,                 0, 0, 1);

        @(posedge clk);
        #2;
        n_tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
